// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl: raster-scan coordinate generator for a single image frame.
//
// A start request in IDLE captures the frame size and the block then offers
// (col,row) coordinates in raster order. It advances one coordinate per
// px_valid/px_ready handshake. After the last pixel it pulses done for one
// cycle and returns to IDLE. Abort or reset ends the frame immediately.
//
// Ports
//   clk, n_rst            clock, asynchronous active-low reset
//   start, abort          frame start (sampled in IDLE), synchronous abort
//   width_m1, height_m1   frame size minus one, captured at start
//   px_ready              downstream accepts the current coordinate
//   px_valid, col, row    offered coordinate
//   sof, eol, eof         first pixel / last column / last pixel markers
//   busy, done            frame in progress / one-cycle completion pulse
module frame_scan_ctrl #(
  parameter int CNT_BITS = 10
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_BITS-1:0] width_m1,
  input  logic [CNT_BITS-1:0] height_m1,
  input  logic                px_ready,
  output logic                px_valid,
  output logic [CNT_BITS-1:0] col,
  output logic [CNT_BITS-1:0] row,
  output logic                sof,
  output logic                eol,
  output logic                eof,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] col_cnt, col_cnt_nxt;
  logic [CNT_BITS-1:0] row_cnt, row_cnt_nxt;
  logic [CNT_BITS-1:0] w_sh, w_sh_nxt;
  logic [CNT_BITS-1:0] h_sh, h_sh_nxt;
  logic                in_scan;

  // Counters run downward so "last column/row" is a compare against zero.
  always_comb begin
    state_nxt   = state;
    col_cnt_nxt = col_cnt;
    row_cnt_nxt = row_cnt;
    w_sh_nxt    = w_sh;
    h_sh_nxt    = h_sh;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          w_sh_nxt    = width_m1;
          h_sh_nxt    = height_m1;
          col_cnt_nxt = width_m1;
          row_cnt_nxt = height_m1;
          state_nxt   = SCAN;
        end
      end
      SCAN: begin
        // Abort wins even over the final transfer.
        if (abort) begin
          state_nxt = IDLE;
        end else if (px_ready) begin
          if (col_cnt != '0) begin
            col_cnt_nxt = col_cnt - 1'b1;
          end else if (row_cnt != '0) begin
            col_cnt_nxt = w_sh;
            row_cnt_nxt = row_cnt - 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      w_sh    <= '0;
      h_sh    <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_cnt_nxt;
      row_cnt <= row_cnt_nxt;
      w_sh    <= w_sh_nxt;
      h_sh    <= h_sh_nxt;
    end
  end

  // All outputs decode registered state only, so they are stable under
  // backpressure. px_ready never reaches any output combinationally.
  assign in_scan  = (state == SCAN);
  assign px_valid = in_scan;
  assign col      = in_scan ? (w_sh - col_cnt) : '0;
  assign row      = in_scan ? (h_sh - row_cnt) : '0;
  assign eol      = in_scan && (col_cnt == '0);
  assign eof      = in_scan && (col_cnt == '0) && (row_cnt == '0);
  assign sof      = in_scan && (col_cnt == w_sh) && (row_cnt == h_sh);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Self-checking bench for frame_scan_ctrl. The reference model holds the
// transfer index of the frame. It derives the expected coordinate and flags
// directly from that index and the frame size.
module tb_frame_scan_ctrl;
  localparam int CB = 10;

  logic          clk = 1'b0;
  logic          n_rst, start, abort, px_ready;
  logic [CB-1:0] width_m1, height_m1;
  logic          px_valid, sof, eol, eof, busy, done;
  logic [CB-1:0] col, row;

  int errors = 0;
  int checks = 0;

  frame_scan_ctrl #(.CNT_BITS(CB)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .width_m1(width_m1), .height_m1(height_m1), .px_ready(px_ready),
    .px_valid(px_valid), .col(col), .row(row), .sof(sof), .eol(eol),
    .eof(eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // kill_mode: 0 none, 1 abort at kill_idx, 2 n_rst pulse at kill_idx.
  // stall_idx: hold px_ready low for 3 cycles when that index is first offered.
  task automatic run_frame(input int w, input int h, input int ready_pct,
                           input bit restart_mid, input int kill_mode,
                           input int kill_idx, input int stall_idx);
    int n, idx, cyc, stall_left;
    bit rdy, stalled;
    logic [CB-1:0] ec, er;
    logic es, eeol, eeof;
    n = (w + 1) * (h + 1);
    idx = 0; cyc = 0; stall_left = 0; stalled = 0;
    @(negedge clk);
    width_m1 = CB'(w); height_m1 = CB'(h); start = 1'b1; px_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (idx < n) begin
      ec   = CB'(idx % (w + 1));
      er   = CB'(idx / (w + 1));
      es   = (idx == 0);
      eeol = (ec == CB'(w));
      eeof = (idx == n - 1);
      checks++;
      if (px_valid !== 1'b1 || col !== ec || row !== er || sof !== es ||
          eol !== eeol || eof !== eeof || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL scan idx=%0d got v=%b c=%0d r=%0d sof=%b eol=%b eof=%b busy=%b done=%b want v=1 c=%0d r=%0d sof=%b eol=%b eof=%b busy=1 done=0",
                 idx, px_valid, col, row, sof, eol, eof, busy, done, ec, er, es, eeol, eeof);
      end
      if (kill_mode == 1 && idx == kill_idx) begin
        abort = 1'b1; px_ready = 1'($urandom_range(1));
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0; px_ready = 1'b0;
        checks++;
        if (px_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL abort got v=%b busy=%b done=%b want 0 0 0", px_valid, busy, done);
        end
        repeat (2) begin
          @(posedge clk);
          @(negedge clk);
          checks++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone got done=%b busy=%b want 0 0", done, busy);
          end
        end
        return;
      end
      if (kill_mode == 2 && idx == kill_idx) begin
        n_rst = 1'b0;
        #1;
        checks++;
        if ({px_valid, sof, eol, eof, busy, done} !== 6'b0 || col !== '0 || row !== '0) begin
          errors++;
          $display("FAIL rst_mid got v=%b sof=%b eol=%b eof=%b busy=%b done=%b c=%0d r=%0d want all 0",
                   px_valid, sof, eol, eof, busy, done, col, row);
        end
        start = 1'b1;
        repeat (2) begin
          @(posedge clk);
          @(negedge clk);
          checks++;
          if (px_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_start got v=%b busy=%b want 0 0", px_valid, busy);
          end
        end
        start = 1'b0;
        n_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (px_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rst_release got v=%b busy=%b want 0 0", px_valid, busy);
        end
        return;
      end
      if (idx == stall_idx && !stalled) begin
        stalled = 1'b1; stall_left = 3;
      end
      if (stall_left > 0) begin
        rdy = 1'b0; stall_left--;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      px_ready = rdy;
      if (restart_mid) begin
        start = 1'($urandom_range(1));
        width_m1 = CB'($urandom_range(9, 5));
        height_m1 = CB'($urandom_range(9, 5));
      end
      @(posedge clk);
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
      if (cyc > 5000) begin
        errors++;
        $display("FAIL timeout idx=%0d want %0d transfers", idx, n);
        break;
      end
    end
    start = 1'b0; px_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || px_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse got done=%b v=%b busy=%b want 1 0 1", done, px_valid, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || px_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after got done=%b busy=%b v=%b want 0 0 0", done, busy, px_valid);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b1; abort = 1'b0; px_ready = 1'b1;
    width_m1 = 10'd3; height_m1 = 10'd3;
    #1;
    checks++;
    if ({px_valid, sof, eol, eof, busy, done} !== 6'b0 || col !== '0 || row !== '0) begin
      errors++;
      $display("FAIL reset got v=%b sof=%b eol=%b eof=%b busy=%b done=%b c=%0d r=%0d want all 0",
               px_valid, sof, eol, eof, busy, done, col, row);
    end
    repeat (2) @(negedge clk);
    start = 1'b0;
    n_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || px_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%b v=%b want 0 0", busy, px_valid);
    end
  endtask

  task automatic test_basic_3x2();
    run_frame(2, 1, 100, 1'b0, 0, 0, -1);
  endtask

  task automatic test_backpressure();
    run_frame(2, 1, 100, 1'b0, 0, 0, 1);
  endtask

  task automatic test_1x1();
    run_frame(0, 0, 100, 1'b0, 0, 0, -1);
    run_frame(0, 3, 60, 1'b0, 0, 0, -1);
    run_frame(4, 0, 60, 1'b0, 0, 0, -1);
  endtask

  task automatic test_abort();
    // abort together with start in IDLE keeps the block idle
    @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || px_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b v=%b want 0 0", busy, px_valid);
    end
    run_frame(3, 3, 70, 1'b0, 1, 5, -1);
    run_frame(3, 3, 70, 1'b0, 0, 0, -1);
  endtask

  task automatic test_reset_midframe();
    run_frame(3, 3, 100, 1'b0, 2, 2, -1);
    run_frame(3, 3, 100, 1'b0, 0, 0, -1);
  endtask

  task automatic test_restart_mid();
    run_frame(2, 2, 60, 1'b1, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_frame(int'($urandom_range(6)), int'($urandom_range(5)),
                int'($urandom_range(90, 30)), 1'($urandom_range(1)), 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_basic_3x2();
    test_backpressure();
    test_1x1();
    test_abort();
    test_reset_midframe();
    test_restart_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_scan_ctrl.md
FRAME_SCAN_CTRL -- requirements
Module: frame_scan_ctrl

Interface
REQ-001 SHALL provide parameter CNT_BITS, default 10: width of the column/row counters and the size inputs.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: frame start request; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1: synchronous frame abort.
REQ-006 SHALL have port width_m1, input, CNT_BITS: image columns minus 1.
REQ-007 SHALL have port height_m1, input, CNT_BITS: image rows minus 1.
REQ-008 SHALL have port px_ready, input, 1: downstream accepts the current pixel coordinate.
REQ-009 SHALL have port px_valid, output, 1: a coordinate is offered.
REQ-010 SHALL have port col, output, CNT_BITS: current column, ascending from 0.
REQ-011 SHALL have port row, output, CNT_BITS: current row, ascending from 0.
REQ-012 SHALL have port sof, output, 1: the current coordinate is the first pixel of the frame.
REQ-013 SHALL have port eol, output, 1: the current coordinate is the last column of a row.
REQ-014 SHALL have port eof, output, 1: the current coordinate is the last pixel of the frame.
REQ-015 SHALL have port busy, output, 1: a frame is in progress (SCAN or DONE).
REQ-016 SHALL have port done, output, 1: one-cycle frame-complete pulse.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, SCAN, DONE.
REQ-018 SHALL perform these actions on a rising edge in IDLE with start=1 and abort=0:
- latch width_m1 and height_m1 into shadow registers;
- load col_cnt=width_m1 and row_cnt=height_m1 as down counters;
- enter SCAN.
REQ-019 SHALL assert px_valid=1 in SCAN only, with no bubble between the start edge and the first coordinate.
REQ-020 SHALL define a transfer as a SCAN cycle with px_valid=1 and px_ready=1; counters change only on a transfer.
REQ-021 SHALL apply these counter rules on a transfer:
- col_cnt!=0: col_cnt decrements;
- col_cnt==0 and row_cnt!=0: col_cnt reloads the latched width_m1, and row_cnt decrements;
- col_cnt==0 and row_cnt==0: the FSM enters DONE.
REQ-022 SHALL derive col = latched width_m1 - col_cnt and row = latched height_m1 - row_cnt, with modulo 2^CNT_BITS arithmetic and no overflow possible.
REQ-023 SHALL derive the flags in SCAN only, and drive them 0 elsewhere:
- eol = (col_cnt==0);
- eof = (col_cnt==0 && row_cnt==0);
- sof = (col_cnt==width && row_cnt==height), both compared against the latched values.
REQ-024 SHALL hold col, row, sof, eol and eof stable while px_valid=1 and px_ready=0 (backpressure).
REQ-025 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE on the next edge.
REQ-026 SHALL ignore start while in SCAN or DONE; size inputs that change mid-frame have no effect.
REQ-027 SHALL, when abort=1 on any edge in SCAN or DONE, return to IDLE without a done pulse; abort in IDLE keeps the FSM in IDLE.
REQ-028 SHALL give abort priority over start and over a simultaneous final transfer.
REQ-029 SHALL treat width_m1=0 and/or height_m1=0 as legal (1 column and/or 1 row), so a 1x1 frame asserts sof, eol and eof together.
REQ-030 SHALL make done and busy registered-state decodes with no combinational path from px_ready to done.

Reset
REQ-031 SHALL, while n_rst=0, immediately force:
- the FSM to IDLE;
- col_cnt, row_cnt and the shadow registers to 0;
- px_valid, sof, eol, eof, busy and done to 0.
REQ-032 SHALL drop px_valid within the reset assertion itself on a reset mid-frame, and SHALL require a new start after reset release.

Verification
REQ-033 SHALL cover a 3x2 frame (width_m1=2, height_m1=1) with px_ready held 1: 6 transfers with (col,row) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); sof on the 1st transfer; eol on the 3rd and 6th; eof on the 6th; done=1 in the cycle after the 6th; busy=0 one cycle later.
REQ-034 SHALL cover backpressure: in the 3x2 frame, drive px_ready=0 for 3 cycles at (1,0); outputs hold (1,0) with px_valid=1; the frame completes with exactly 6 transfers.
REQ-035 SHALL cover a 1x1 frame (width_m1=0, height_m1=0): a single transfer with sof=eol=eof=1, followed by a done pulse.
REQ-036 SHALL cover abort at (1,1) in a 4x4 frame: IDLE on the next edge, px_valid=0, no done pulse; a following start runs a full 16-pixel frame.
REQ-037 SHALL cover n_rst pulsed low at (2,0) in a 4x4 frame: all outputs 0 during reset; start pulses are ignored until n_rst=1; after release a start rescans from (0,0).
REQ-038 SHALL cover start re-asserted during SCAN with different sizes: no effect, and the frame finishes with the originally latched dimensions.
